// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select, load/branch/MDU stall detection and MDU busy tracking
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LAT     = 4,
    parameter int DIV_LAT     = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  RsD,
    input  logic [REG_ADDR_W-1:0]  RtD,
    input  logic [REG_ADDR_W-1:0]  RsE,
    input  logic [REG_ADDR_W-1:0]  RtE,
    input  logic [REG_ADDR_W-1:0]  WriteRegE,
    input  logic [REG_ADDR_W-1:0]  WriteRegM,
    input  logic [REG_ADDR_W-1:0]  WriteRegW,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemtoRegE,
    input  logic                   MemtoRegM,
    input  logic                   BranchD,
    input  logic                   MduUseD,
    input  logic                   MduStartE,
    input  logic                   MduOpE,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   ForwardAD,
    output logic                   ForwardBD,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushE,
    output logic                   MduBusy,
    output logic                   MduDone,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [STALL_CNT_W-1:0] SC_ONE = STALL_CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             done_next;

    logic e_writes_d;
    logic m_load_writes_d;
    logic lwstall;
    logic brstall;
    logic mdustall;
    logic stall;

    // A producer matches only when it actually writes a non-zero register.
    function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic                  we);
        return we && (src != '0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input logic [REG_ADDR_W-1:0] dst_m,
                                           input logic                  we_m,
                                           input logic [REG_ADDR_W-1:0] dst_w,
                                           input logic                  we_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (reg_hit(src, dst_m, we_m)) begin
            sel = 2'b10;
        end else if (reg_hit(src, dst_w, we_w)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
        ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
        ForwardAD = reg_hit(RsD, WriteRegM, RegWriteM);
        ForwardBD = reg_hit(RtD, WriteRegM, RegWriteM);
    end

    always_comb begin
        e_writes_d      = RegWriteE && (WriteRegE != '0) &&
                          ((WriteRegE == RsD) || (WriteRegE == RtD));
        m_load_writes_d = MemtoRegM && (WriteRegM != '0) &&
                          ((WriteRegM == RsD) || (WriteRegM == RtD));
        lwstall         = MemtoRegE && e_writes_d;
        brstall         = BranchD && (e_writes_d || m_load_writes_d);
        mdustall        = MduUseD && ((state == BUSY) || ((state == IDLE) && MduStartE));
        stall           = rst_n && (lwstall || brstall || mdustall);
    end

    assign StallF  = stall;
    assign StallD  = stall;
    assign FlushE  = stall;
    assign MduBusy = (state == BUSY);

    // A start arriving while BUSY is dropped: the counter is neither reloaded nor extended.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (MduStartE) begin
                    state_next = BUSY;
                    cnt_next   = MduOpE ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                if (cnt == CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            MduDone <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            MduDone <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (stall && (StallCount != '1)) begin
            StallCount <= StallCount + SC_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vectors checked against a cycle-indexed behavioural model
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int ML = 4;
    localparam int DL = 32;
    localparam int SW = 4;
    localparam int SC_MAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic          BranchD, MduUseD, MduStartE, MduOpE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          ForwardAD, ForwardBD, StallF, StallD, FlushE, MduBusy, MduDone;
    logic [SW-1:0] StallCount;

    hazard_scoreboard #(
        .REG_ADDR_W (AW),
        .MUL_LAT    (ML),
        .DIV_LAT    (DL),
        .STALL_CNT_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .MduUseD(MduUseD), .MduStartE(MduStartE), .MduOpE(MduOpE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .MduBusy(MduBusy), .MduDone(MduDone), .StallCount(StallCount)
    );

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Model: the MDU is an interval of cycle numbers (start, busy_until], done one cycle later.
    int cyc = 0;
    int mstart = -1;
    int busy_until = -1;
    int done_at = -1;
    int sc_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hit(input logic [AW-1:0] x, input logic [AW-1:0] w, input logic we);
        return we && (x != 0) && (x == w);
    endfunction

    function automatic logic [1:0] exp_fe(input logic [AW-1:0] x);
        if (hit(x, WriteRegM, RegWriteM)) return 2'b10;
        if (hit(x, WriteRegW, RegWriteW)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_busy();
        return (cyc > mstart) && (cyc <= busy_until);
    endfunction

    function automatic bit exp_stall();
        bit e_dep, m_dep, lw, br, md;
        e_dep = RegWriteE && (WriteRegE != 0) && ((WriteRegE == RsD) || (WriteRegE == RtD));
        m_dep = MemtoRegM && (WriteRegM != 0) && ((WriteRegM == RsD) || (WriteRegM == RtD));
        lw    = MemtoRegE && e_dep;
        br    = BranchD && (e_dep || m_dep);
        md    = MduUseD && (model_busy() || MduStartE);
        return rst_n && (lw || br || md);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mstart = -1; busy_until = -1; done_at = -1; sc_exp = 0;
        end else begin
            if (exp_stall() && sc_exp < SC_MAX) sc_exp++;
            if (MduStartE) begin
                if (model_busy()) begin
                    if (check_en) begin
                        miscompares++;
                        $display("FAIL mdu_start_while_busy at cycle %0d", cyc);
                    end
                end else begin
                    mstart     = cyc;
                    busy_until = cyc + (MduOpE ? DL : ML);
                    done_at    = busy_until + 1;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("ForwardAE", 32'(ForwardAE), 32'(exp_fe(RsE)));
            check("ForwardBE", 32'(ForwardBE), 32'(exp_fe(RtE)));
            check("ForwardAD", 32'(ForwardAD), 32'(hit(RsD, WriteRegM, RegWriteM)));
            check("ForwardBD", 32'(ForwardBD), 32'(hit(RtD, WriteRegM, RegWriteM)));
            check("StallF", 32'(StallF), 32'(exp_stall()));
            check("StallD", 32'(StallD), 32'(exp_stall()));
            check("FlushE", 32'(FlushE), 32'(exp_stall()));
            check("MduBusy", 32'(MduBusy), 32'(model_busy()));
            check("MduDone", 32'(MduDone), 32'(cyc == done_at));
            check("StallCount", 32'(StallCount), 32'(sc_exp));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
        BranchD = 0; MduUseD = 0; MduStartE = 0; MduOpE = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        check_en = 1'b1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [AW-1:0] rs, rt, wm, ww;
        logic          rwm, rww;
        logic [1:0]    fa, fb;
        logic          ad, bd;
    } fwd_vec_t;

    fwd_vec_t fwd_tab[7] = '{
        '{rs:3, rt:3, wm:3, ww:3, rwm:1, rww:1, fa:2'b10, fb:2'b10, ad:1, bd:1},
        '{rs:0, rt:3, wm:3, ww:3, rwm:1, rww:1, fa:2'b00, fb:2'b10, ad:0, bd:1},
        '{rs:5, rt:6, wm:5, ww:5, rwm:0, rww:1, fa:2'b01, fb:2'b00, ad:0, bd:0},
        '{rs:5, rt:6, wm:7, ww:6, rwm:1, rww:1, fa:2'b00, fb:2'b01, ad:0, bd:0},
        '{rs:4, rt:4, wm:4, ww:9, rwm:1, rww:1, fa:2'b10, fb:2'b10, ad:1, bd:1},
        '{rs:0, rt:0, wm:0, ww:0, rwm:1, rww:1, fa:2'b00, fb:2'b00, ad:0, bd:0},
        '{rs:7, rt:8, wm:7, ww:8, rwm:0, rww:0, fa:2'b00, fb:2'b00, ad:0, bd:0}
    };

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        next_cycle();
        do_reset();

        // Forwarding table
        foreach (fwd_tab[i]) begin
            RsE = fwd_tab[i].rs; RtE = fwd_tab[i].rt;
            RsD = fwd_tab[i].rs; RtD = fwd_tab[i].rt;
            WriteRegM = fwd_tab[i].wm; RegWriteM = fwd_tab[i].rwm;
            WriteRegW = fwd_tab[i].ww; RegWriteW = fwd_tab[i].rww;
            @(negedge clk);
            check("lit_fwd_ae", 32'(ForwardAE), 32'(fwd_tab[i].fa));
            check("lit_fwd_be", 32'(ForwardBE), 32'(fwd_tab[i].fb));
            check("lit_fwd_ad", 32'(ForwardAD), 32'(fwd_tab[i].ad));
            check("lit_fwd_bd", 32'(ForwardBD), 32'(fwd_tab[i].bd));
            next_cycle();
        end
        clear_inputs();

        // Load-use: one stall cycle, then forward the load result from M
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8;
        @(negedge clk);
        check("lit_lw_stall", 32'({StallF, StallD, FlushE}), 32'(3'b111));
        check("lit_lw_cnt0", 32'(StallCount), 32'(0));
        next_cycle();
        clear_inputs();
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8; RtE = 8;
        @(negedge clk);
        check("lit_lw_fwd_be", 32'(ForwardBE), 32'(2'b10));
        check("lit_lw_nostall", 32'(StallF), 32'(0));
        check("lit_lw_cnt1", 32'(StallCount), 32'(1));
        next_cycle();
        clear_inputs();

        // Branch operand produced by an ALU op in E
        BranchD = 1; RsD = 9; RegWriteE = 1; WriteRegE = 9;
        @(negedge clk);
        check("lit_br_stall", 32'(StallD), 32'(1));
        next_cycle();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 9;
        @(negedge clk);
        check("lit_br_fwd_ad", 32'(ForwardAD), 32'(1));
        check("lit_br_nostall", 32'(StallD), 32'(0));
        check("lit_br_cnt2", 32'(StallCount), 32'(2));
        next_cycle();
        clear_inputs();

        // Multiply then divide, dependent op held in D
        for (int op = 0; op < 2; op++) begin
            int lat;
            lat = (op == 0) ? ML : DL;
            MduUseD = 1; MduOpE = op[0];
            for (int k = 0; k <= lat + 1; k++) begin
                MduStartE = (k == 0);
                @(negedge clk);
                check("lit_mdu_stall", 32'(StallD), 32'(k <= lat));
                check("lit_mdu_busy", 32'(MduBusy), 32'((k >= 1) && (k <= lat)));
                check("lit_mdu_done", 32'(MduDone), 32'(k == lat + 1));
                next_cycle();
            end
            clear_inputs();
        end

        // Reset in the middle of a divide
        MduUseD = 1; MduOpE = 1;
        for (int k = 0; k < 5; k++) begin
            MduStartE = (k == 0);
            next_cycle();
        end
        MduStartE = 0;
        rst_n = 1'b0;
        @(negedge clk);
        check("lit_rst_stall", 32'({StallF, StallD, FlushE}), 32'(0));
        check("lit_rst_fwd_comb", 32'(ForwardAE), 32'(0));
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_rst_busy", 32'(MduBusy), 32'(0));
        check("lit_rst_cnt", 32'(StallCount), 32'(0));
        check("lit_rst_nostall", 32'(StallD), 32'(0));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("lit_rst_nodone", 32'(MduDone), 32'(0));
            next_cycle();
        end
        clear_inputs();

        // Saturation of the 4-bit stall counter
        do_reset();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 12; RsD = 12;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("lit_sat_cnt", 32'(StallCount), 32'((k < SC_MAX) ? k : SC_MAX));
            next_cycle();
        end
        @(negedge clk);
        check("lit_sat_final", 32'(StallCount), 32'(SC_MAX));
        next_cycle();
        clear_inputs();
        next_cycle();

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
